// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: Row/Col scan position, display_on, HSYNC/VSYNC and one-cycle line/frame/vblank ticks.
// Define VGA_FRAME_CNT_EN to add a 16-bit frame_count output that steps on every frame_start.
module vga_timing_gen #(
   parameter int   H_VISIBLE   = 640,
   parameter int   H_FRONT     = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BACK      = 48,
   parameter int   V_VISIBLE   = 480,
   parameter int   V_FRONT     = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BACK      = 33,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        pix_en,
   output logic [9:0]  Row,
   output logic [9:0]  Col,
   output logic        display_on,
   output logic        HSYNC,
   output logic        VSYNC,
   output logic        line_start,
   output logic        frame_start,
   output logic        vblank_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must each fit in the 10-bit counters");
   end

   logic [9:0] next_col;
   logic [9:0] next_row;
   logic       next_line;
   logic       next_origin;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_col = Col + 10'd1;
      next_row = Row;
      if (Col == H_LAST) begin
         next_col = '0;
         next_row = (Row == V_LAST) ? '0 : Row + 10'd1;
      end
   end

   assign next_line   = (next_col == '0);
   assign next_origin = next_line && (next_row == '0);

   // Decode uses the next-state counters so display_on and syncs describe the pixel Row/Col show.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Col          <= H_LAST;
         Row          <= V_LAST;
         display_on   <= 1'b0;
         HSYNC        <= ~SYNC_ACTIVE;
         VSYNC        <= ~SYNC_ACTIVE;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
      end else begin
         // Ticks fall on the next edge regardless of pix_en, so a held position emits one pulse only.
         line_start   <= pix_en && next_line;
         frame_start  <= pix_en && next_origin;
         vblank_start <= pix_en && next_line && (next_row == V_VIS_END);
         if (pix_en) begin
            Col        <= next_col;
            Row        <= next_row;
            display_on <= (next_col < H_VIS_END) && (next_row < V_VIS_END);
            HSYNC      <= (next_col >= HS_FIRST && next_col <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            VSYNC      <= (next_row >= VS_FIRST && next_row <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         end
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         frame_count <= '0;
      end else if (pix_en && next_origin) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the 640x480@60 Hz raster timing that drives the pattern generator.
- Produces the Row/Col scan position, display_on, HSYNC/VSYNC to the connector, and one-cycle line/frame/vblank ticks.
- The vblank tick is the clean replacement for deriving an animation strobe from a Row compare.
- Sits between the pixel-clock PLL and the pattern generator; it is the producing end of the Row/Col/display_on interface.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of HSYNC/VSYNC (0 = active-low)

Ports:
CLK  in  1  pixel clock (25.175 MHz nominal)
RST_N  in  1  asynchronous active-low reset
pix_en  in  1  clock enable; the raster advances one pixel per CLK with pix_en=1
Row  out  10  current line, 0..V_TOTAL-1
Col  out  10  current pixel, 0..H_TOTAL-1
display_on  out  1  1 when Col<H_VISIBLE and Row<V_VISIBLE
HSYNC  out  1  horizontal sync
VSYNC  out  1  vertical sync
line_start  out  1  one-cycle pulse on entering Col=0
frame_start  out  1  one-cycle pulse on entering (Row=0, Col=0)
vblank_start  out  1  one-cycle pulse on entering (Row=V_VISIBLE, Col=0)

Behaviour:
- Clock and reset: one clock (CLK). RST_N is asynchronous and active-low.
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset values: Col=H_TOTAL-1, Row=V_TOTAL-1, display_on=0, HSYNC=VSYNC=~SYNC_ACTIVE, all ticks 0.
  - As a result, the first advance after reset lands on (0,0).
- Advance, on a CLK edge with pix_en=1:
  - Col increments.
  - At Col=H_TOTAL-1, Col wraps to 0 and Row increments.
  - At Row=V_TOTAL-1 with Col=H_TOTAL-1, Row wraps to 0.
  - Widths are 10-bit unsigned; no value outside the valid range is ever output.
- Hold, on a CLK edge with pix_en=0: Row, Col, display_on, HSYNC and VSYNC all hold.
- Alignment and latency:
  - All outputs are registered and mutually aligned: display_on/HSYNC/VSYNC describe the same pixel that Row/Col show in that cycle.
  - They are computed from the next-state counter values, so there is zero relative skew.
  - Output latency is 1 CLK from the enabled edge.
- HSYNC equals SYNC_ACTIVE for Col in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751 at defaults.
- VSYNC equals SYNC_ACTIVE for Row in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491 at defaults, for the whole line.
- Ticks:
  - Each tick is high for exactly one CLK: the cycle immediately after the enabled edge that moved the counters into the tick position.
  - A tick deasserts on the next CLK even if pix_en=0 holds the position.
  - line_start and frame_start are both high at (0,0).
  - vblank_start and line_start are both high at (480,0).
- Frame period with pix_en held at 1: 420000 CLK. Line period: 800 CLK.
- Reset mid-frame: all outputs return to reset values asynchronously and no tick is emitted during reset. After release, the first enabled edge yields (0,0) with frame_start=1.
- There is no state machine beyond the two counters plus the registered decode.
- Parameter legality: H_TOTAL≤1024 and V_TOTAL≤1024 are checked by an elaboration-time assertion.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined: adds output frame_count [15:0].
  - Resets to 0.
  - Increments by 1, registered, in the same cycle frame_start is asserted.
  - Wraps 65535 -> 0.
  - Holds otherwise.
  - Reels and other animations may sample it.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
1. Assert RST_N=0 mid-frame -> Row=524, Col=799, display_on=0, HSYNC=VSYNC=1, ticks 0. Release with pix_en=1 -> next cycle Row=0, Col=0, display_on=1, frame_start=1, line_start=1; following cycle both ticks 0.
2. pix_en=1, run one line -> Col 639 display_on=1; Col 640 display_on=0; HSYNC=0 exactly for Col 656..751; Col 799 -> 0 with Row incremented and line_start=1.
3. Run a full frame -> VSYNC=0 only on Rows 490..491; vblank_start=1 once at (480,0); next frame_start exactly 420000 cycles after the previous one; display_on high count per frame = 307200.
4. Toggle pix_en=0 for 5 cycles at Col=799/Row=479 -> Row/Col/display_on/syncs frozen; no ticks during the hold. Re-enable -> (480,0) with vblank_start=1 for one cycle only.
5. Reset asserted at Row=300, Col=400 for 3 cycles -> immediate reset values. After release, the frame restarts at (0,0) with no spurious vblank_start.
6. With VGA_FRAME_CNT_EN defined, run 3 frames from reset -> frame_count 1, 2, 3, changing in the frame_start cycles. Preload via 65536 frames (or force) to confirm 65535 -> 0 wrap.
